// File: rtl/loop_driver_pkg.sv
// Shared types and constants for the loop_driver host sequencer.
// Holds the FSM state encoding and the watchdog limit helper.
package loop_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam int DATA_W_DEF  = 16;
   localparam int N_TERMS_DEF = 4;

   // RUN cycle by which done must have arrived: 3 cycles per term plus slack
   function automatic int WD_LIMIT(input int n);
      return 3 * n + 6;
   endfunction

endpackage

// File: rtl/loop_driver_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at LIMIT once reached; at_limit flags that value.
module sat_counter #(
   parameter int W     = 3,
   parameter int LIMIT = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count,
   output logic         at_limit
);

   localparam logic [W-1:0] LIM = W'(LIMIT);

   assign at_limit = (count == LIM);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (inc && !at_limit)
         count <= count + 1'b1;
   end

endmodule

// File: rtl/loop_driver.sv
// Host-side sequencer for the iterative multiply/sum controller.
// Define LOOP_DRIVER_WATCHDOG_EN to abort jobs whose done never arrives.
module loop_driver
   import loop_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int N_TERMS = N_TERMS_DEF,
   parameter int CNT_W   = $clog2(N_TERMS + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic [DATA_W-1:0] x_out,
   output logic              ctrl_rst,
   output logic              ctrl_s,
   input  logic              ctrl_read,
   input  logic              ctrl_sum,
   input  logic              ctrl_done,
   input  logic [DATA_W-1:0] res_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_err,
   output logic              busy
);

   state_t           state;
   logic             in_run;
   logic             accept;
   logic             timeout;
   logic [CNT_W-1:0] iter_cnt;
   logic             iter_full;

   assign in_run = (state == RUN);
   assign accept = in_ready && in_valid;

   sat_counter #(
      .W     (CNT_W),
      .LIMIT (N_TERMS)
   ) u_iter (
      .clk      (clk),
      .rst      (rst),
      .clr      (accept),
      .inc      (in_run && ctrl_sum),
      .count    (iter_cnt),
      .at_limit (iter_full)
   );

   assign ctrl_s = in_run && iter_full;

   // read strobe and raw count are observed by the host only
   logic unused_sigs;
   assign unused_sigs = ^{ctrl_read, iter_cnt};

`ifdef LOOP_DRIVER_WATCHDOG_EN
   // count == c in RUN cycle c, so hitting LIMIT-1 lands HOLD on LIMIT
   localparam int WD_MAX = WD_LIMIT(N_TERMS) - 1;
   localparam int WD_W   = $clog2(WD_MAX + 1);

   logic [WD_W-1:0] wd_cnt;
   logic            wd_hit;

   sat_counter #(
      .W     (WD_W),
      .LIMIT (WD_MAX)
   ) u_wd (
      .clk      (clk),
      .rst      (rst),
      .clr      (!in_run),
      .inc      (in_run),
      .count    (wd_cnt),
      .at_limit (wd_hit)
   );

   logic unused_wd;
   assign unused_wd = ^wd_cnt;
   assign timeout   = in_run && wd_hit;
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         x_out     <= '0;
         out_data  <= '0;
         out_err   <= 1'b0;
         ctrl_rst  <= 1'b1;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  x_out    <= in_data;
                  state    <= RUN;
                  ctrl_rst <= 1'b0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            RUN: begin
               if (ctrl_done || timeout) begin
                  out_data  <= ctrl_done ? res_in : '0;
                  out_err   <= !ctrl_done;
                  state     <= HOLD;
                  ctrl_rst  <= 1'b1;
                  out_valid <= 1'b1;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  out_err   <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               ctrl_rst  <= 1'b1;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule
